matmul_rect: RTL and testbench

MATMUL_RECT -- requirements
Module: matmul_rect

---
 rtl/matmul_rect.sv | 187 ++++++++++++++++++
 tb/tb_matmul_rect.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_rect.sv
`default_nettype none
// ============================================================================
// Module      : matmul_rect
// Description : Sequential rectangular matrix multiplier Z[MxP] = X[MxK]*Y[KxP]
//               over external row-major X/Y/Z memories, one MAC per cycle,
//               with optional saturation and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_rect #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 72,
  parameter int ADDR_WIDTH = 12,
  parameter int M          = 8,
  parameter int K          = 8,
  parameter int P          = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  sat_en,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_dout,
  output logic [ADDR_WIDTH-1:0] y_addr,
  input  logic [DATA_WIDTH-1:0] y_dout,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic [DATA_WIDTH-1:0] z_din,
  output logic                  z_wr_en
);

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_e;

  localparam logic [DATA_WIDTH-1:0] c_ZMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_ZMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         i_q, i_d;
  logic [ADDR_WIDTH-1:0]         j_q, j_d;
  // k counts MAC issues, then is reused to count the DRAIN cycles
  logic [ADDR_WIDTH-1:0]         k_q, k_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          sat_q, sat_d;
  logic                          ovf_q, ovf_d;
  logic [RD_LAT-1:0]             vld_q;

  logic                          w_issue;
  logic                          w_vld_out;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]   w_prod_ext;
  logic [ACC_WIDTH-DATA_WIDTH:0] w_hi;
  logic                          w_in_range;

  assign w_issue    = (state_q == MAC);
  assign w_vld_out  = vld_q[RD_LAT-1];
  assign w_prod     = $signed(x_dout) * $signed(y_dout);
  assign w_prod_ext = ACC_WIDTH'(w_prod);

  // Result fits in DATA_WIDTH when all bits from the sign position up agree
  assign w_hi       = acc_q[ACC_WIDTH-1:DATA_WIDTH-1];
  assign w_in_range = (&w_hi) | ~(|w_hi);

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign ovf     = ovf_q;
  assign z_wr_en = (state_q == WRITE);

  // Row-major addresses; all forced to zero when not in use
  always_comb begin
    x_addr = '0;
    y_addr = '0;
    z_addr = '0;
    z_din  = '0;
    if (state_q == MAC) begin
      x_addr = i_q * ADDR_WIDTH'(K) + k_q;
      y_addr = k_q * ADDR_WIDTH'(P) + j_q;
    end
    if (state_q == WRITE) begin
      z_addr = i_q * ADDR_WIDTH'(P) + j_q;
      if (w_in_range || !sat_q) begin
        z_din = acc_q[DATA_WIDTH-1:0];
      end else begin
        z_din = acc_q[ACC_WIDTH-1] ? c_ZMIN : c_ZMAX;
      end
    end
  end

  // Read-valid pipeline: a bit leaves the end exactly when its data arrives
  generate
    if (RD_LAT == 1) begin : g_vld_one
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld_q <= '0;
        else          vld_q <= w_issue;
      end
    end else begin : g_vld_shift
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld_q <= '0;
        else          vld_q <= {vld_q[RD_LAT-2:0], w_issue};
      end
    end
  endgenerate

  // Next-state, counter and accumulator logic
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    if (w_vld_out) acc_d = acc_q + w_prod_ext;
    case (state_q)
      IDLE: begin
        if (start) begin
          sat_d   = sat_en;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (k_q == ADDR_WIDTH'(K - 1)) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (k_q == ADDR_WIDTH'(RD_LAT - 1)) begin
          k_d     = '0;
          state_d = WRITE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      WRITE: begin
        acc_d = '0;
        if (!w_in_range) ovf_d = 1'b1;
        if (j_q == ADDR_WIDTH'(P - 1)) begin
          j_d = '0;
          if (i_q == ADDR_WIDTH'(M - 1)) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = MAC;
          end
        end else begin
          j_d     = j_q + 1'b1;
          state_d = MAC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_rect.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_rect
// Description : Directed self-checking bench for matmul_rect (four configs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_rect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic sat_en = 1'b0;
  logic st_a = 1'b0, st_b = 1'b0, st_c = 1'b0, st_d = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A: 2x2x2, 32-bit, RD_LAT=1
  logic a_busy, a_done, a_ovf, a_zwe;
  logic [11:0] a_xa, a_ya, a_za;
  logic [31:0] a_xd, a_yd, a_zd;
  logic [31:0] a_xm[16], a_ym[16];
  always @(posedge clk) begin
    a_xd <= a_xm[a_xa[3:0]];
    a_yd <= a_ym[a_ya[3:0]];
  end
  matmul_rect #(.DATA_WIDTH(32), .ACC_WIDTH(72), .ADDR_WIDTH(12), .M(2), .K(2), .P(2), .RD_LAT(1)) u_a (
    .clock(clk), .reset_n(rst_n), .start(st_a), .sat_en(sat_en), .busy(a_busy), .done(a_done), .ovf(a_ovf),
    .x_addr(a_xa), .x_dout(a_xd), .y_addr(a_ya), .y_dout(a_yd), .z_addr(a_za), .z_din(a_zd), .z_wr_en(a_zwe));

  // B: 2x2x2, 8-bit, saturation tests
  logic b_busy, b_done, b_ovf, b_zwe;
  logic [11:0] b_xa, b_ya, b_za;
  logic [7:0]  b_xd, b_yd, b_zd;
  logic [7:0]  b_xm[16], b_ym[16];
  always @(posedge clk) begin
    b_xd <= b_xm[b_xa[3:0]];
    b_yd <= b_ym[b_ya[3:0]];
  end
  matmul_rect #(.DATA_WIDTH(8), .ACC_WIDTH(24), .ADDR_WIDTH(12), .M(2), .K(2), .P(2), .RD_LAT(1)) u_b (
    .clock(clk), .reset_n(rst_n), .start(st_b), .sat_en(sat_en), .busy(b_busy), .done(b_done), .ovf(b_ovf),
    .x_addr(b_xa), .x_dout(b_xd), .y_addr(b_ya), .y_dout(b_yd), .z_addr(b_za), .z_din(b_zd), .z_wr_en(b_zwe));

  // C: 3x4x2, 16-bit, RD_LAT=3
  logic c_busy, c_done, c_ovf, c_zwe;
  logic [11:0] c_xa, c_ya, c_za;
  logic [15:0] c_xd, c_yd, c_zd;
  logic [15:0] c_xm[16], c_ym[16], c_xp[3], c_yp[3];
  always @(posedge clk) begin
    c_xp[0] <= c_xm[c_xa[3:0]]; c_xp[1] <= c_xp[0]; c_xp[2] <= c_xp[1];
    c_yp[0] <= c_ym[c_ya[3:0]]; c_yp[1] <= c_yp[0]; c_yp[2] <= c_yp[1];
  end
  assign c_xd = c_xp[2];
  assign c_yd = c_yp[2];
  matmul_rect #(.DATA_WIDTH(16), .ACC_WIDTH(40), .ADDR_WIDTH(12), .M(3), .K(4), .P(2), .RD_LAT(3)) u_c (
    .clock(clk), .reset_n(rst_n), .start(st_c), .sat_en(sat_en), .busy(c_busy), .done(c_done), .ovf(c_ovf),
    .x_addr(c_xa), .x_dout(c_xd), .y_addr(c_ya), .y_dout(c_yd), .z_addr(c_za), .z_din(c_zd), .z_wr_en(c_zwe));

  // D: degenerate 1x1x1, 8-bit, RD_LAT=2
  logic d_busy, d_done, d_ovf, d_zwe;
  logic [11:0] d_xa, d_ya, d_za;
  logic [7:0]  d_xd, d_yd, d_zd;
  logic [7:0]  d_xm[16], d_ym[16], d_xp[2], d_yp[2];
  always @(posedge clk) begin
    d_xp[0] <= d_xm[d_xa[3:0]]; d_xp[1] <= d_xp[0];
    d_yp[0] <= d_ym[d_ya[3:0]]; d_yp[1] <= d_yp[0];
  end
  assign d_xd = d_xp[1];
  assign d_yd = d_yp[1];
  matmul_rect #(.DATA_WIDTH(8), .ACC_WIDTH(16), .ADDR_WIDTH(12), .M(1), .K(1), .P(1), .RD_LAT(2)) u_d (
    .clock(clk), .reset_n(rst_n), .start(st_d), .sat_en(sat_en), .busy(d_busy), .done(d_done), .ovf(d_ovf),
    .x_addr(d_xa), .x_dout(d_xd), .y_addr(d_ya), .y_dout(d_yd), .z_addr(d_za), .z_din(d_zd), .z_wr_en(d_zwe));

  typedef struct {int cyc; int addr; longint data;} wr_t;
  wr_t qa[$], qb[$], qc[$], qd[$];
  int  dna[$], dnb[$], dnc[$], dnd[$];

  function automatic wr_t mk(input int c, input logic [11:0] a, input longint d);
    wr_t w;
    w.cyc = c; w.addr = int'(a); w.data = d;
    return w;
  endfunction

  // Log every Z write and done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (a_zwe) qa.push_back(mk(cyc, a_za, longint'($signed(a_zd))));
    if (b_zwe) qb.push_back(mk(cyc, b_za, longint'($signed(b_zd))));
    if (c_zwe) qc.push_back(mk(cyc, c_za, longint'($signed(c_zd))));
    if (d_zwe) qd.push_back(mk(cyc, d_za, longint'($signed(d_zd))));
    if (a_done) dna.push_back(cyc);
    if (b_done) dnb.push_back(cyc);
    if (c_done) dnc.push_back(cyc);
    if (d_done) dnd.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_wr(input string tag, input wr_t w, input int t0, input int ecyc,
                        input int eaddr, input longint edata);
    chk({tag, "_cyc"}, 64'(w.cyc - t0), 64'(ecyc));
    chk({tag, "_addr"}, 64'(w.addr), 64'(eaddr));
    chk({tag, "_data"}, w.data, edata);
  endtask

  // Pulse start for one cycle on the selected instance; t0 is the start cycle
  task automatic go(input int sel, input bit sat, output int t0);
    @(posedge clk); #1;
    t0 = cyc; sat_en = sat;
    st_a = (sel == 0); st_b = (sel == 1); st_c = (sel == 2); st_d = (sel == 3);
    @(posedge clk); #1;
    st_a = 0; st_b = 0; st_c = 0; st_d = 0; sat_en = 0;
  endtask

  task automatic run_a(input string tag);
    int t0;
    longint ea[4] = '{19, 22, 43, 50};
    qa.delete(); dna.delete();
    go(0, 0, t0);
    chk({tag, "_busy"}, 64'(a_busy), 64'd1);
    repeat (24) @(posedge clk); #1;
    chk({tag, "_nwr"}, 64'(qa.size()), 64'd4);
    for (int n = 0; n < qa.size() && n < 4; n++) chk_wr(tag, qa[n], t0, 4 * (n + 1), n, ea[n]);
    chk({tag, "_ndone"}, 64'(dna.size()), 64'd1);
    if (dna.size() > 0) chk({tag, "_done_cyc"}, 64'(dna[0] - t0), 64'd17);
    chk({tag, "_ovf"}, 64'(a_ovf), 64'd0);
    chk({tag, "_idle"}, 64'(a_busy), 64'd0);
  endtask

  task automatic run_b(input string tag, input bit sat, input longint edata, input bit eovf);
    int t0;
    qb.delete();
    go(1, sat, t0);
    chk({tag, "_ovf_clr"}, 64'(b_ovf), 64'd0);
    repeat (20) @(posedge clk); #1;
    chk({tag, "_nwr"}, 64'(qb.size()), 64'd4);
    for (int n = 0; n < qb.size() && n < 4; n++) chk_wr(tag, qb[n], t0, 4 * (n + 1), n, edata);
    chk({tag, "_ovf"}, 64'(b_ovf), 64'(eovf));
  endtask

  initial begin
    int t0;
    longint gold[6];
    foreach (a_xm[n]) begin
      a_xm[n] = '0; a_ym[n] = '0; b_xm[n] = '0; b_ym[n] = '0;
      c_xm[n] = '0; c_ym[n] = '0; d_xm[n] = '0; d_ym[n] = '0;
    end
    a_xm[0] = 1; a_xm[1] = 2; a_xm[2] = 3; a_xm[3] = 4;
    a_ym[0] = 5; a_ym[1] = 6; a_ym[2] = 7; a_ym[3] = 8;
    d_xm[0] = 8'hFD; d_ym[0] = 8'd5;
    for (int n = 0; n < 12; n++) c_xm[n] = 16'(int'($urandom_range(180)) - 90);
    for (int n = 0; n < 8; n++)  c_ym[n] = 16'(int'($urandom_range(180)) - 90);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++) begin
        gold[i*2+j] = 0;
        for (int k = 0; k < 4; k++)
          gold[i*2+j] += longint'($signed(c_xm[i*4+k])) * longint'($signed(c_ym[k*2+j]));
      end

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_ovf", 64'(a_ovf), 64'd0);
    chk("rst_zwe", 64'(a_zwe), 64'd0);
    chk("rst_xaddr", 64'(a_xa), 64'd0);
    chk("rst_zaddr", 64'(a_za), 64'd0);
    chk("rst_zdin", 64'(a_zd), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_stays", 64'(a_busy), 64'd0);

    // Basic 2x2 product
    run_a("A1");

    // Saturation / wrap / negative clamp / ovf clear on new start
    foreach (b_xm[n]) begin b_xm[n] = 8'd127; b_ym[n] = 8'd127; end
    run_b("Bsat", 1'b1, 127, 1'b1);
    run_b("Bwrap", 1'b0, 2, 1'b1);
    foreach (b_xm[n]) b_xm[n] = 8'h80;
    run_b("Bneg", 1'b1, -128, 1'b1);
    foreach (b_xm[n]) begin b_xm[n] = 8'd1; b_ym[n] = 8'd1; end
    run_b("Bsmall", 1'b1, 2, 1'b0);

    // Rectangular, deeper read latency
    qc.delete(); dnc.delete();
    go(2, 0, t0);
    repeat (55) @(posedge clk); #1;
    chk("C_nwr", 64'(qc.size()), 64'd6);
    for (int n = 0; n < qc.size() && n < 6; n++) chk_wr("C", qc[n], t0, 8 * (n + 1), n, gold[n]);
    if (dnc.size() > 0) chk("C_done_cyc", 64'(dnc[0] - t0), 64'd49);
    else chk("C_ndone", 64'(dnc.size()), 64'd1);
    chk("C_ovf", 64'(c_ovf), 64'd0);

    // Degenerate 1x1x1
    qd.delete(); dnd.delete();
    go(3, 0, t0);
    repeat (8) @(posedge clk); #1;
    chk("D_nwr", 64'(qd.size()), 64'd1);
    if (qd.size() > 0) chk_wr("D", qd[0], t0, 4, 0, -15);
    if (dnd.size() > 0) chk("D_done_cyc", 64'(dnd[0] - t0), 64'd5);
    else chk("D_ndone", 64'(dnd.size()), 64'd1);

    // Start while busy, then abort with reset mid-MAC
    qa.delete(); dna.delete();
    go(0, 0, t0);
    @(posedge clk); #1; st_a = 1'b1;
    @(posedge clk); #1; st_a = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("rst_async_busy", 64'(a_busy), 64'd0);
    chk("rst_async_zwe", 64'(a_zwe), 64'd0);
    chk("rst_async_xaddr", 64'(a_xa), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (25) @(posedge clk); #1;
    chk("abort_nwr", 64'(qa.size()), 64'd1);
    if (qa.size() > 0) chk_wr("abort", qa[0], t0, 4, 0, 19);
    chk("abort_ndone", 64'(dna.size()), 64'd0);
    chk("abort_busy", 64'(a_busy), 64'd0);

    // Fresh run; start in the DONE cycle must be ignored
    qa.delete(); dna.delete();
    go(0, 0, t0);
    repeat (16) @(posedge clk); #1;
    chk("A2_done_now", 64'(a_done), 64'd1);
    st_a = 1'b1;
    @(posedge clk); #1; st_a = 1'b0;
    chk("A2_start_in_done_ignored", 64'(a_busy), 64'd0);
    repeat (10) @(posedge clk); #1;
    chk("A2_nwr", 64'(qa.size()), 64'd4);
    for (int n = 0; n < qa.size() && n < 4; n++)
      chk_wr("A2", qa[n], t0, 4 * (n + 1), n, (n == 0) ? 19 : (n == 1) ? 22 : (n == 2) ? 43 : 50);
    chk("A2_ovf", 64'(a_ovf), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
